// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch sequencer.
//   fetch_state_t : sequencer state (RUN, HALT)
//   fetch_entry_t : one fetched {pc, instr} pair as buffered toward decode
//   DEFAULT_RESET_PC / DEFAULT_ROM_AW : default parameter values for fetch_ctrl
//   addr_legal()  : word-aligned and inside a ROM of 2^rom_aw words
package fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          DEFAULT_ROM_AW   = 8;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic addr_legal(input logic [31:0] addr, input int rom_aw);
    return (addr[1:0] == 2'b00) && ((addr >> (rom_aw + 2)) == 32'd0);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry synchronous FIFO of fetch_entry_t.
// Ports:
//   clk, reset : clock and synchronous active-high reset (clears entries to 0)
//   push, din  : write din at the tail
//   pop        : drop the head entry (caller guarantees count != 0)
//   flush      : empty the FIFO; wins over push and pop
//   head       : current head entry (stale contents when count == 0)
//   count      : number of valid entries, 0..2
import fetch_pkg::*;

module fetch_fifo (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer between PC/branch logic and decode.
// Drives the synchronous ROM address, tracks the single in-flight read,
// buffers up to two fetched words and handles redirects and fetch faults.
// Optional feature macro: FETCH_CTRL_PERF_EN adds perf_fetched / perf_stall.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   rom_addr  [31:0] out  : byte address to ROM (data returns next cycle)
//   rom_data  [31:0] in   : registered ROM output
//   redirect_valid, redirect_pc : single-cycle fetch restart request
//   out_valid, out_ready, out_pc, out_instr : head entry handshake to decode
//   fault                 : sticky misaligned / out-of-range fetch indication
//   perf_fetched, perf_stall (FETCH_CTRL_PERF_EN only) : pop / stall counters
//
// state | meaning
// RUN   | fetching; issues, buffers and delivers instructions
// HALT  | faulted; no issue, FIFO held empty, redirects ignored until reset
import fetch_pkg::*;

module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          ROM_AW   = DEFAULT_ROM_AW
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        fault
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic [31:0]  inflight_pc_q;
  logic         inflight_q;
  logic         fault_q;

  logic         run;
  logic         redir;
  logic         redir_ok;
  logic         pop;
  logic         push;
  logic         flush;
  logic         pc_ok;
  logic         seq_issue;
  logic         seq_fault;
  logic [2:0]   occ;
  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t din;

  assign run      = (state_q == RUN);
  assign redir    = run && redirect_valid;
  assign redir_ok = redir && addr_legal(redirect_pc, ROM_AW);

  assign out_valid = (count != 2'd0) && !redirect_valid && run;
  assign pop       = out_valid && out_ready;

  // Entries that will occupy the FIFO next cycle before any new issue lands.
  assign occ = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};

  assign pc_ok     = addr_legal(pc_q, ROM_AW);
  assign seq_issue = run && !redirect_valid && (occ < 3'd2) && pc_ok;
  // An out-of-range sequential fetch only faults once everything fetched
  // ahead of it has been handed to decode, so the last legal words still
  // reach decode before HALT flushes the buffer.
  assign seq_fault = run && !redirect_valid && !pc_ok && (occ == 3'd0);

  assign push  = inflight_q && run && !redirect_valid;
  assign flush = redir || !run;

  assign rom_addr = redir_ok ? redirect_pc : pc_q;

  assign din.pc    = inflight_pc_q;
  assign din.instr = rom_data;

  fetch_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (din),
    .head  (head),
    .count (count)
  );

  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign fault     = fault_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'd0;
      fault_q       <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (redirect_valid) begin
            if (redir_ok) begin
              pc_q          <= redirect_pc + 32'd4;
              inflight_q    <= 1'b1;
              inflight_pc_q <= redirect_pc;
            end else begin
              state_q    <= HALT;
              fault_q    <= 1'b1;
              inflight_q <= 1'b0;
            end
          end else if (seq_issue) begin
            pc_q          <= pc_q + 32'd4;
            inflight_q    <= 1'b1;
            inflight_pc_q <= pc_q;
          end else if (seq_fault) begin
            state_q    <= HALT;
            fault_q    <= 1'b1;
            inflight_q <= 1'b0;
          end else begin
            inflight_q <= 1'b0;
          end
        end
        HALT: begin
          inflight_q <= 1'b0;
          fault_q    <= 1'b1;
        end
        default: begin
          state_q    <= HALT;
          fault_q    <= 1'b1;
          inflight_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= 32'd0;
      perf_stall   <= 32'd0;
    end else begin
      if (pop) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (out_valid && !out_ready) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule
